// File: rtl/mirror_spi_master.sv
// rtl/mirror_spi_master.sv - Framed SPI mode-0 master streaming bytes MSB first under one slave select
module mirror_spi_master #(
  parameter int CLK_DIV     = 4,
  parameter int FRAME_BYTES = 600
) (
  input  logic       master_clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       abort,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       s_clk,
  output logic       ss,
  output logic       dataout,
  output logic       busy,
  output logic       frame_done,
  output logic [9:0] byte_count
);

  typedef enum logic [2:0] {IDLE, SETUP, LOAD, SHIFT, HOLD} state_t;

  localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [10:0] FRAME_LEN = 11'(FRAME_BYTES);

  state_t     state_q;
  logic [7:0] div_cnt_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic       byte_ready_q;
  logic       s_clk_q;
  logic       ss_q;
  logic       dataout_q;
  logic       busy_q;
  logic       frame_done_q;
  logic [9:0] byte_count_q;

  logic       div_done;
  logic [9:0] byte_count_d;
  logic       more_bytes;

  // Half-period tick and end-of-byte bookkeeping
  always_comb begin
    div_done     = (div_cnt_q == DIV_LAST);
    byte_count_d = byte_count_q + 10'd1;
    more_bytes   = ({1'b0, byte_count_d} < FRAME_LEN);
  end

  // Frame sequencer with all pin-facing outputs registered
  always_ff @(posedge master_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      div_cnt_q    <= 8'd0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 7'd0;
      byte_ready_q <= 1'b0;
      s_clk_q      <= 1'b0;
      ss_q         <= 1'b1;
      dataout_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      byte_count_q <= 10'd0;
    end else begin
      frame_done_q <= 1'b0;
      if (state_q != IDLE && abort) begin
        // Abort drops the frame on the spot; byte_count keeps what was sent
        state_q      <= IDLE;
        byte_ready_q <= 1'b0;
        s_clk_q      <= 1'b0;
        ss_q         <= 1'b1;
        dataout_q    <= 1'b0;
        busy_q       <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (frame_start) begin
              state_q      <= SETUP;
              div_cnt_q    <= 8'd0;
              ss_q         <= 1'b0;
              busy_q       <= 1'b1;
              byte_count_q <= 10'd0;
            end
          end
          SETUP: begin
            if (div_done) begin
              state_q      <= LOAD;
              div_cnt_q    <= 8'd0;
              byte_ready_q <= 1'b1;
            end else begin
              div_cnt_q <= div_cnt_q + 8'd1;
            end
          end
          LOAD: begin
            if (byte_valid) begin
              state_q      <= SHIFT;
              byte_ready_q <= 1'b0;
              shift_q      <= byte_in[6:0];
              dataout_q    <= byte_in[7];
              div_cnt_q    <= 8'd0;
              bit_cnt_q    <= 3'd0;
            end
          end
          SHIFT: begin
            if (div_done) begin
              div_cnt_q <= 8'd0;
              s_clk_q   <= ~s_clk_q;
              if (s_clk_q) begin
                // Falling edge: either present the next bit or close the byte
                if (bit_cnt_q == 3'd7) begin
                  bit_cnt_q    <= 3'd0;
                  byte_count_q <= byte_count_d;
                  if (more_bytes) begin
                    state_q      <= LOAD;
                    byte_ready_q <= 1'b1;
                  end else begin
                    state_q <= HOLD;
                  end
                end else begin
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  dataout_q <= shift_q[6];
                  shift_q   <= {shift_q[5:0], 1'b0};
                end
              end
            end else begin
              div_cnt_q <= div_cnt_q + 8'd1;
            end
          end
          HOLD: begin
            if (div_done) begin
              state_q      <= IDLE;
              div_cnt_q    <= 8'd0;
              ss_q         <= 1'b1;
              dataout_q    <= 1'b0;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
            end else begin
              div_cnt_q <= div_cnt_q + 8'd1;
            end
          end
          default: begin
            state_q <= IDLE;
            ss_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign byte_ready = byte_ready_q;
  assign s_clk      = s_clk_q;
  assign ss         = ss_q;
  assign dataout    = dataout_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_mirror_spi_master.sv
// tb/tb_mirror_spi_master.sv - Scoreboard bench for mirror_spi_master (small frame and default frame)
module tb_mirror_spi_master;

  localparam int DIV  = 4;
  localparam int FB_A = 2;
  localparam int FB_B = 600;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       fs_a = 1'b0, ab_a = 1'b0, bv_a = 1'b0;
  logic [7:0] bi_a = 8'd0;
  logic       br_a, sclk_a, ss_a, do_a, busy_a, fd_a;
  logic [9:0] bc_a;

  logic       fs_b = 1'b0, ab_b = 1'b0, bv_b = 1'b0;
  logic [7:0] bi_b = 8'd0;
  logic       br_b, sclk_b, ss_b, do_b, busy_b, fd_b;
  logic [9:0] bc_b;

  mirror_spi_master #(.CLK_DIV(DIV), .FRAME_BYTES(FB_A)) dut_a (
    .master_clk(clk), .rst_n(rst_n), .frame_start(fs_a), .abort(ab_a),
    .byte_in(bi_a), .byte_valid(bv_a), .byte_ready(br_a), .s_clk(sclk_a),
    .ss(ss_a), .dataout(do_a), .busy(busy_a), .frame_done(fd_a), .byte_count(bc_a)
  );

  mirror_spi_master dut_b (
    .master_clk(clk), .rst_n(rst_n), .frame_start(fs_b), .abort(ab_b),
    .byte_in(bi_b), .byte_valid(bv_b), .byte_ready(br_b), .s_clk(sclk_b),
    .ss(ss_b), .dataout(do_b), .busy(busy_b), .frame_done(fd_b), .byte_count(bc_b)
  );

  int checks = 0;
  int errors = 0;

  // Expected serial bit streams, MSB of each accepted byte first
  bit exp_a[$];
  bit exp_b[$];

  int  rises_a = 0, falls_a = 0, fdone_a = 0;
  int  rises_b = 0, falls_b = 0, fdone_b = 0;
  logic psclk_a = 1'b0, pdo_a = 1'b0, pss_a = 1'b1;
  logic psclk_b = 1'b0, pdo_b = 1'b0;
  time last_fall_a_t = 0, ss_rise_a_t = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: decode s_clk edges, compare each sampled bit with the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      check("ss_tracks_busy_a", longint'(ss_a), longint'(!busy_a));
      if (sclk_a && !psclk_a) begin
        rises_a++;
        check("rise_ss_low_a", longint'(ss_a), 0);
        check("rise_data_stable_a", longint'(do_a), longint'(pdo_a));
        check("bit_available_a", longint'(exp_a.size() > 0), 1);
        if (exp_a.size() > 0) check("bit_a", longint'(do_a), longint'(exp_a.pop_front()));
      end
      if (!sclk_a && psclk_a) begin
        falls_a++;
        last_fall_a_t = $time - 5;
      end
      if (ss_a && !pss_a) ss_rise_a_t = $time - 5;
      if (fd_a) fdone_a++;

      if (sclk_b && !psclk_b) begin
        rises_b++;
        check("rise_ss_low_b", longint'(ss_b), 0);
        check("rise_data_stable_b", longint'(do_b), longint'(pdo_b));
        check("bit_available_b", longint'(exp_b.size() > 0), 1);
        if (exp_b.size() > 0) check("bit_b", longint'(do_b), longint'(exp_b.pop_front()));
      end
      if (!sclk_b && psclk_b) falls_b++;
      if (fd_b) fdone_b++;
    end
    psclk_a = sclk_a; pdo_a = do_a; pss_a = ss_a;
    psclk_b = sclk_b; pdo_b = do_b;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Offer one byte until accepted; returns the time of the accepting edge
  task automatic offer(input bit side_b, input logic [7:0] v, output time t_x);
    int n = 0;
    if (side_b) begin bi_b = v; bv_b = 1'b1; end
    else        begin bi_a = v; bv_a = 1'b1; end
    while (!(side_b ? br_b : br_a) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(side_b ? "byte_accepted_b" : "byte_accepted_a", longint'(side_b ? br_b : br_a), 1);
    t_x = $time + 5;
    for (int i = 7; i >= 0; i--) begin
      if (side_b) exp_b.push_back(v[i]);
      else        exp_a.push_back(v[i]);
    end
    @(negedge clk);
    bv_a = 1'b0;
    bv_b = 1'b0;
  endtask

  task automatic wait_idle(input bit side_b, input int limit);
    int n = 0;
    while ((side_b ? busy_b : busy_a) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(side_b ? "frame_end_b" : "frame_end_a", longint'(side_b ? busy_b : busy_a), 0);
    tick(2);
  endtask

  task automatic start_a();
    fs_a = 1'b1;
    tick();
    fs_a = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    time        tx, tr;
    int         r0, f0, d0, n, bad, r;
    logic       dsave, prev;
    logic [7:0] rb;

    // Reset state
    tick(3);
    check("rst_ss_a", longint'(ss_a), 1);
    check("rst_sclk_a", longint'(sclk_a), 0);
    check("rst_busy_a", longint'(busy_a), 0);
    check("rst_ready_a", longint'(br_a), 0);
    check("rst_done_a", longint'(fd_a), 0);
    check("rst_bc_a", longint'(bc_a), 0);
    check("rst_do_a", longint'(do_a), 0);
    check("rst_ss_b", longint'(ss_b), 1);
    rst_n = 1'b1;
    tick(5);
    check("idle_after_rst_busy", longint'(busy_a), 0);
    check("idle_after_rst_ss", longint'(ss_a), 1);

    // abort together with frame_start in IDLE: frame_start wins
    fs_a = 1'b1; ab_a = 1'b1;
    tick();
    fs_a = 1'b0; ab_a = 1'b0;
    check("start_busy", longint'(busy_a), 1);
    check("start_ss", longint'(ss_a), 0);
    check("start_bc", longint'(bc_a), 0);

    // Directed frame 0x36, 0xA5
    r0 = rises_a; f0 = falls_a; d0 = fdone_a;
    offer(1'b0, 8'h36, tx);
    n = 0;
    while (!sclk_a && n < 100) begin @(negedge clk); n++; end
    tr = $time - 5;
    check("first_rise_delay_ns", longint'(tr - tx), 10 * DIV);
    offer(1'b0, 8'hA5, tx);
    wait_idle(1'b0, 2000);
    check("rises_frame", rises_a - r0, 16);
    check("falls_frame", falls_a - f0, 16);
    check("frame_done_count", fdone_a - d0, 1);
    check("bc_frame", longint'(bc_a), 2);
    check("ss_release_delay_ns", longint'(ss_rise_a_t - last_fall_a_t), 10 * DIV);
    check("bits_left", exp_a.size(), 0);

    // Stall of 50 cycles between bytes
    d0 = fdone_a;
    start_a();
    rb = 8'($urandom_range(255, 0));
    offer(1'b0, rb, tx);
    n = 0;
    while (!br_a && n < 500) begin @(negedge clk); n++; end
    check("stall_reached_load", longint'(br_a), 1);
    r0 = rises_a; dsave = do_a; bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (sclk_a || ss_a || do_a != dsave) bad++;
    end
    check("stall_pins_bad_cycles", bad, 0);
    check("stall_no_edges", rises_a - r0, 0);
    rb = 8'($urandom_range(255, 0));
    offer(1'b0, rb, tx);
    wait_idle(1'b0, 2000);
    check("stall_bc", longint'(bc_a), 2);
    check("stall_done", fdone_a - d0, 1);
    check("stall_bits_left", exp_a.size(), 0);

    // Abort after the third rising edge of byte 1
    d0 = fdone_a;
    start_a();
    rb = 8'($urandom_range(255, 0));
    offer(1'b0, rb, tx);
    r = 0; n = 0; prev = sclk_a;
    while (r < 3 && n < 500) begin
      @(negedge clk);
      n++;
      if (sclk_a && !prev) r++;
      prev = sclk_a;
    end
    check("abort_saw_3_rises", r, 3);
    ab_a = 1'b1;
    tick();
    ab_a = 1'b0;
    check("abort_ss", longint'(ss_a), 1);
    check("abort_sclk", longint'(sclk_a), 0);
    check("abort_busy", longint'(busy_a), 0);
    check("abort_do", longint'(do_a), 0);
    check("abort_bc", longint'(bc_a), 0);
    r0 = rises_a;
    tick(20);
    check("abort_no_done", fdone_a - d0, 0);
    check("abort_no_edges", rises_a - r0, 0);
    exp_a.delete();
    d0 = fdone_a;
    start_a();
    for (int i = 0; i < FB_A; i++) begin
      rb = 8'($urandom_range(255, 0));
      offer(1'b0, rb, tx);
    end
    wait_idle(1'b0, 2000);
    check("post_abort_bc", longint'(bc_a), 2);
    check("post_abort_done", fdone_a - d0, 1);
    check("post_abort_bits_left", exp_a.size(), 0);

    // Asynchronous reset in the middle of the second byte
    start_a();
    rb = 8'($urandom_range(255, 0));
    offer(1'b0, rb, tx);
    rb = 8'($urandom_range(255, 0));
    offer(1'b0, rb, tx);
    tick(10);
    check("pre_reset_bc", longint'(bc_a), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ss", longint'(ss_a), 1);
    check("async_rst_sclk", longint'(sclk_a), 0);
    check("async_rst_bc", longint'(bc_a), 0);
    check("async_rst_busy", longint'(busy_a), 0);
    check("async_rst_ready", longint'(br_a), 0);
    r0 = rises_a;
    tick(3);
    check("rst_held_sclk", longint'(sclk_a), 0);
    exp_a.delete();
    rst_n = 1'b1;
    tick(10);
    check("post_rst_idle_busy", longint'(busy_a), 0);
    check("post_rst_idle_ss", longint'(ss_a), 1);
    check("post_rst_no_edges", rises_a - r0, 0);

    // Default-size frame with a random stream and a stray mid-frame frame_start
    fs_b = 1'b1;
    tick();
    fs_b = 1'b0;
    for (int i = 0; i < FB_B; i++) begin
      rb = 8'($urandom_range(255, 0));
      offer(1'b1, rb, tx);
      if (i == 300) begin
        fs_b = 1'b1;
        tick();
        fs_b = 1'b0;
        check("midframe_busy", longint'(busy_b), 1);
        check("midframe_bc", longint'(bc_b), 300);
      end
    end
    wait_idle(1'b1, 2000);
    check("default_rises", rises_b, 8 * FB_B);
    check("default_falls", falls_b, 8 * FB_B);
    check("default_bc", longint'(bc_b), FB_B);
    check("default_done", fdone_b, 1);
    check("default_bits_left", exp_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mirror_spi_master.md
MIRROR_SPI_MASTER -- requirements
Module: mirror_spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4: SPI half-period in master_clk cycles; legal range 4..255.
REQ-002 Parameter FRAME_BYTES, default 600: bytes per frame (40 columns x 15 rows); legal range 1..1023.
REQ-003 master_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 frame_start  in  1  single-cycle request to begin a frame.
REQ-006 abort  in  1  synchronous request to terminate a frame in progress.
REQ-007 byte_in  in  8  byte to transmit, MSB first.
REQ-008 byte_valid  in  1  byte_in holds a valid byte.
REQ-009 byte_ready  out  1  block accepts byte_in this cycle.
REQ-010 s_clk  out  1  SPI clock, mode 0 (idle low).
REQ-011 ss  out  1  slave select, active low.
REQ-012 dataout  out  1  MOSI.
REQ-013 busy  out  1  frame in progress.
REQ-014 frame_done  out  1  single-cycle pulse at normal frame end.
REQ-015 byte_count  out  10  bytes fully shifted in the current or last frame.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, SETUP, LOAD, SHIFT and HOLD.
REQ-017 IDLE: ss=1, s_clk=0, dataout=0, busy=0, byte_ready=0; frame_start=1 SHALL go to SETUP, clear byte_count and drive ss=0 and busy=1 on the next cycle.
REQ-018 SETUP SHALL last CLK_DIV cycles with s_clk=0, then go to LOAD.
REQ-019 LOAD: byte_ready=1 and s_clk=0; a transfer occurs when byte_valid and byte_ready are both 1 in the same cycle, which loads the shift register, drives byte_in[7] on dataout and enters SHIFT.
REQ-020 LOAD with byte_valid=0 SHALL stall indefinitely, with ss held 0, s_clk held 0 and dataout unchanged.
REQ-021 SHIFT: s_clk SHALL rise CLK_DIV cycles after entry or after the previous fall, and fall CLK_DIV cycles after each rise.
REQ-022 dataout SHALL change only in the cycle s_clk falls, presenting the next bit; it SHALL be stable across every rising edge.
REQ-023 Each byte SHALL produce exactly 8 rising and 8 falling s_clk edges, and byte_count SHALL increment in the cycle of the 8th fall.
REQ-024 After the 8th fall, SHIFT SHALL go to LOAD if byte_count < FRAME_BYTES, otherwise to HOLD.
REQ-025 HOLD SHALL keep ss=0 and s_clk=0 for CLK_DIV cycles, then set ss=1, pulse frame_done for one cycle, clear busy and return to IDLE.
REQ-026 ss SHALL remain 0 continuously from SETUP through HOLD, with no deassertion between bytes.
REQ-027 frame_start SHALL be ignored in any state other than IDLE.
REQ-028 abort=1 in any non-IDLE state SHALL, on the next cycle, give ss=1, s_clk=0, dataout=0, busy=0 and IDLE; there SHALL be no frame_done pulse and byte_count SHALL hold its value.
REQ-029 abort and frame_start asserted together in IDLE: frame_start SHALL win; abort SHALL have no effect in IDLE.
REQ-030 byte_count SHALL be 10 bits unsigned and SHALL never exceed FRAME_BYTES.

Reset
REQ-031 rst_n=0 SHALL immediately, asynchronously to master_clk, force IDLE with ss=1, s_clk=0, dataout=0, byte_ready=0, busy=0, frame_done=0 and byte_count=0.
REQ-032 Reset asserted mid-byte SHALL discard the partial byte, and no s_clk edge SHALL appear after reset assertion.
REQ-033 After rst_n deasserts, the block SHALL stay in IDLE until frame_start.

Verification
REQ-034 Reset: pulse rst_n low during SHIFT -> same cycle ss=1, s_clk=0, byte_count=0, busy=0.
REQ-035 Frame of FRAME_BYTES=2, CLK_DIV=4, bytes 0x36 then 0xA5 offered back-to-back ->
- bits sampled at rising edges read 00110110 then 10100101;
- exactly 16 rising edges;
- ss low throughout;
- first rise 4 cycles after the first transfer;
- ss high 4 cycles after the last fall;
- one frame_done pulse;
- byte_count=2.
REQ-036 Stall: byte_valid withheld 50 cycles between bytes -> s_clk low and ss low for the whole gap, no extra edges, data intact.
REQ-037 Abort after the 3rd rising edge of byte 1 -> ss=1 the next cycle, no frame_done, byte_count=0; a new frame_start then runs a full normal frame.
REQ-038 Defaults (FRAME_BYTES=600, CLK_DIV=4) with a random byte stream ->
- 4800 rising edges;
- byte_count=600;
- a single frame_done;
- frame_start pulsed mid-frame has no effect.
